// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte streams.
// A message lock keeps the owner granted until it sends a LAST byte.
module uart_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int GUARD_CYCLES = 0,
    parameter int BUSY_TMO     = 15
) (
    input  logic                ICLK_50,
    input  logic                IRST,
    input  logic [NREQ-1:0]     IREQ_VALID,
    input  logic [8*NREQ-1:0]   IREQ_DATA,
    input  logic [NREQ-1:0]     IREQ_LAST,
    output logic [NREQ-1:0]     OREQ_READY,
    output logic [7:0]          OTX_DATA,
    output logic                OTX_EN,
    input  logic                ITX_BUSY,
    output logic [NREQ-1:0]     OGRANT,
    output logic                OLOCKED,
    output logic                OERR,
    output logic [15:0]         OBYTE_CNT
);

    localparam int PW = $clog2(NREQ);
    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam int TW = $clog2(BUSY_TMO + 1);

    typedef enum logic [2:0] {
        ARB,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        GUARD
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   sel;
    logic            found;
    logic [NREQ-1:0] elig;
    logic [GW-1:0]   guard_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic [15:0]     byte_cnt;
    logic            grant;
    logic            tmo_hit;
    logic            guard_done;

    // While locked only the owner may win; the search starts at ptr.
    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        elig  = OLOCKED ? (IREQ_VALID & OGRANT) : IREQ_VALID;
        found = 1'b0;
        sel   = '0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
            idx = sum[PW-1:0];
            if (!found && elig[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign grant      = (state == ARB) && !ITX_BUSY && found;
    assign OREQ_READY = grant ? (NREQ'(1) << sel) : '0;
    assign OTX_EN     = (state == ISSUE);
    assign OBYTE_CNT  = byte_cnt;
    assign tmo_hit    = (tmo_cnt == TW'(BUSY_TMO - 1));

    always_comb begin
        if (GUARD_CYCLES <= 1) guard_done = 1'b1;
        else guard_done = (guard_cnt == GW'(GUARD_CYCLES - 1));
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ARB:       if (grant) state_nx = ISSUE;
            ISSUE:     state_nx = WAIT_BUSY;
            WAIT_BUSY: begin
                if (ITX_BUSY) state_nx = WAIT_DONE;
                else if (tmo_hit) state_nx = GUARD;
            end
            WAIT_DONE: if (!ITX_BUSY) state_nx = GUARD;
            GUARD:     if (guard_done) state_nx = ARB;
            default:   state_nx = ARB;
        endcase
    end

    always_ff @(posedge ICLK_50) begin
        if (IRST) begin
            state     <= ARB;
            ptr       <= '0;
            guard_cnt <= '0;
            tmo_cnt   <= '0;
            byte_cnt  <= '0;
            OTX_DATA  <= '0;
            OGRANT    <= '0;
            OLOCKED   <= 1'b0;
            OERR      <= 1'b0;
        end else begin
            state <= state_nx;
            if (grant) begin
                OTX_DATA <= IREQ_DATA[8*sel +: 8];
                OGRANT   <= NREQ'(1) << sel;
                ptr      <= (sel == PW'(NREQ - 1)) ? '0 : sel + 1'b1;
                OLOCKED  <= ~IREQ_LAST[sel];
            end
            if (state == ISSUE) begin
                byte_cnt <= byte_cnt + 16'd1;
                tmo_cnt  <= '0;
            end
            if (state == WAIT_BUSY && !ITX_BUSY) begin
                tmo_cnt <= tmo_cnt + 1'b1;
                if (tmo_hit) OERR <= 1'b1;
            end
            if (state == GUARD)
                guard_cnt <= guard_done ? '0 : guard_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple transmitter model.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  valid = '0;
    logic [31:0] data = '0;
    logic [3:0]  last = '0;
    logic [3:0]  ready;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        busy;
    logic [3:0]  grant;
    logic        locked;
    logic        err;
    logic [15:0] cnt;

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;
    bit tx_dead = 1'b0;
    bit hold_busy = 1'b0;

    always #10 clk = ~clk;

    uart_tx_arbiter #(.NREQ(4), .GUARD_CYCLES(3), .BUSY_TMO(15)) dut (
        .ICLK_50(clk), .IRST(rst),
        .IREQ_VALID(valid), .IREQ_DATA(data), .IREQ_LAST(last),
        .OREQ_READY(ready), .OTX_DATA(tx_data), .OTX_EN(tx_en),
        .ITX_BUSY(busy), .OGRANT(grant), .OLOCKED(locked),
        .OERR(err), .OBYTE_CNT(cnt)
    );

    // Transmitter: busy for 4 cycles starting the cycle after enable.
    always @(posedge clk) begin
        if (tx_en && !tx_dead) busy_cnt <= 4;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign busy = (busy_cnt != 0) || hold_busy;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (ready != 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic settle_and_reset();
        valid = '0;
        for (int i = 0; i < 40 && busy; i++) tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        settle_and_reset();
        checks++;
        if ({tx_en, tx_data, grant, locked, err, ready} !== '0) begin
            errors++;
            $display("FAIL reset_outs: got en=%b data=%h grant=%b lock=%b err=%b rdy=%b want all 0",
                     tx_en, tx_data, grant, locked, err, ready);
        end
        checks++;
        if (cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %h want 0000", cnt);
        end
    endtask

    task automatic test_single();
        bit bad = 1'b0;
        settle_and_reset();
        valid = 4'b0001;
        data[7:0] = 8'hA5;
        last = 4'b1111;
        #1;
        checks++;
        if (ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_ready: got %b want 0001", ready);
        end
        tick();
        checks++;
        if (tx_en !== 1'b1 || tx_data !== 8'hA5 || locked !== 1'b0 || grant !== 4'b0001) begin
            errors++;
            $display("FAIL single_issue: got en=%b data=%h lock=%b grant=%b want 1 a5 0 0001",
                     tx_en, tx_data, locked, grant);
        end
        data[7:0] = 8'hA6;
        tick();
        checks++;
        if (cnt !== 16'd1 || tx_en !== 1'b0) begin
            errors++;
            $display("FAIL single_cnt: got cnt=%0d en=%b want 1 0", cnt, tx_en);
        end
        for (int k = 3; k <= 9; k++) begin
            tick();
            #1;
            if (ready !== 4'b0000) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL single_early_grant: ready seen before busy fell + guard, want none");
        end
        tick();
        #1;
        checks++;
        if (ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_next_grant: got %b want 0001", ready);
        end
        tick();
        valid = '0;
    endtask

    task automatic test_round_robin();
        bit ok;
        int order[5] = '{0, 1, 2, 3, 0};
        settle_and_reset();
        valid = 4'b1111;
        data = 32'h13121110;
        last = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_ready(ok);
            checks++;
            if (!ok || ready !== (4'b0001 << order[n])) begin
                errors++;
                $display("FAIL rr_ready%0d: got %b want %b", n, ready, 4'b0001 << order[n]);
            end
            tick();
            checks++;
            if (grant !== (4'b0001 << order[n]) || tx_data !== 8'(8'h10 + order[n])
                || tx_en !== 1'b1) begin
                errors++;
                $display("FAIL rr_issue%0d: got grant=%b data=%h en=%b want %b %h 1",
                         n, grant, tx_data, tx_en, 4'b0001 << order[n], 8'(8'h10 + order[n]));
            end
        end
        valid = '0;
    endtask

    task automatic test_lock();
        bit ok;
        bit bad = 1'b0;
        settle_and_reset();
        valid = 4'b0010;
        data = 32'h00_00_41_00;
        last = 4'b1101;
        wait_ready(ok);
        checks++;
        if (!ok || ready !== 4'b0010) begin
            errors++;
            $display("FAIL lock_first: got %b want 0010", ready);
        end
        tick();
        valid = 4'b0101;
        for (int i = 0; i < 50; i++) begin
            tick();
            #1;
            if (ready !== 4'b0000 || locked !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL lock_hold: grant to other requester or lock dropped, want locked idle");
        end
        valid = 4'b0111;
        data[15:8] = 8'h42;
        last = 4'b1111;
        wait_ready(ok);
        checks++;
        if (!ok || ready !== 4'b0010) begin
            errors++;
            $display("FAIL lock_second: got %b want 0010", ready);
        end
        tick();
        valid = 4'b0101;
        checks++;
        if (tx_data !== 8'h42 || locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_release: got data=%h lock=%b want 42 0", tx_data, locked);
        end
        wait_ready(ok);
        checks++;
        if (!ok || ready !== 4'b0100) begin
            errors++;
            $display("FAIL lock_next: got %b want 0100", ready);
        end
        tick();
        valid = '0;
    endtask

    task automatic test_timeout();
        bit ok;
        settle_and_reset();
        tx_dead = 1'b1;
        valid = 4'b0001;
        data[7:0] = 8'hAA;
        last = 4'b1111;
        wait_ready(ok);
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (i == 1) data[7:0] = 8'hBB;
            if (i == 16) begin
                checks++;
                if (err !== 1'b0) begin
                    errors++;
                    $display("FAIL tmo_early: got err=%b want 0", err);
                end
            end
            if (i == 17) begin
                checks++;
                if (err !== 1'b1) begin
                    errors++;
                    $display("FAIL tmo_set: got err=%b want 1", err);
                end
            end
        end
        tx_dead = 1'b0;
        wait_ready(ok);
        checks++;
        if (!ok || ready !== 4'b0001) begin
            errors++;
            $display("FAIL tmo_next_grant: got %b want 0001", ready);
        end
        tick();
        valid = '0;
        checks++;
        if (tx_data !== 8'hBB || tx_en !== 1'b1) begin
            errors++;
            $display("FAIL tmo_next_issue: got data=%h en=%b want bb 1", tx_data, tx_en);
        end
        for (int i = 0; i < 12; i++) tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_sticky: got err=%b want 1", err);
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        bit bad = 1'b0;
        settle_and_reset();
        valid = 4'b0001;
        data = 32'h00_00_66_55;
        last = 4'b1111;
        wait_ready(ok);
        tick();
        tick();
        hold_busy = 1'b1;
        valid = 4'b0011;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({tx_en, tx_data, grant, locked, err, ready} !== '0 || cnt !== 16'd0) begin
            errors++;
            $display("FAIL midreset_outs: got en=%b data=%h grant=%b lock=%b err=%b rdy=%b cnt=%0d want 0",
                     tx_en, tx_data, grant, locked, err, ready, cnt);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            #1;
            if (tx_en !== 1'b0 || ready !== 4'b0000) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL midreset_busy_hold: grant or enable while busy, want none");
        end
        hold_busy = 1'b0;
        wait_ready(ok);
        checks++;
        if (!ok || ready !== 4'b0001) begin
            errors++;
            $display("FAIL midreset_first: got %b want 0001", ready);
        end
        tick();
        valid = '0;
        checks++;
        if (tx_en !== 1'b1 || tx_data !== 8'h55) begin
            errors++;
            $display("FAIL midreset_issue: got en=%b data=%h want 1 55", tx_en, tx_data);
        end
    endtask

    task automatic test_guard_wrap();
        bit ok;
        bit seen = 1'b0;
        int fall = -1;
        int rdy = -1;
        settle_and_reset();
        valid = 4'b0001;
        data[7:0] = 8'h77;
        last = 4'b1111;
        wait_ready(ok);
        tick();
        data[7:0] = 8'h78;
        for (int c = 0; c < 40; c++) begin
            tick();
            #1;
            if (busy) seen = 1'b1;
            if (seen && fall < 0 && !busy) fall = c;
            if (ready != 0) begin
                rdy = c;
                break;
            end
        end
        checks++;
        if (fall < 0 || rdy - fall !== 4) begin
            errors++;
            $display("FAIL guard_gap: got ready %0d cycles after busy fell, want 4", rdy - fall);
        end
        tick();
        valid = '0;
        for (int i = 0; i < 20; i++) tick();
        force dut.byte_cnt = 16'hFFFF;
        tick();
        release dut.byte_cnt;
        valid = 4'b0001;
        data[7:0] = 8'h99;
        wait_ready(ok);
        tick();
        valid = '0;
        tick();
        checks++;
        if (cnt !== 16'h0000) begin
            errors++;
            $display("FAIL cnt_wrap: got %h want 0000", cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_timeout();
        test_reset_midframe();
        test_guard_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
